// File: rtl/complex_mac_pkg.sv
// Shared constants and helpers for the complex multiply-accumulate block.
package complex_mac_pkg;

    localparam int LATENCY      = 6;
    localparam int CORE_LATENCY = LATENCY - 1;
    localparam int DEF_AWIDTH   = 16;
    localparam int DEF_BWIDTH   = 16;
    localparam int DEF_GUARD    = 8;

    function automatic int owidth(input int aw, input int bw, input int guard);
        return aw + bw + 1 + guard;
    endfunction

    // Control bits that travel alongside each sample's data.
    typedef struct packed {
        logic valid;
        logic acc_en;
        logic last;
    } tag_t;

endpackage

// File: rtl/complex_mult_core.sv
// Five-stage pipelined complex product using the 3-multiplier form; data only.
module complex_mult_core #(
    parameter int AWIDTH = 16,
    parameter int BWIDTH = 16
) (
    input  logic                            clk,
    input  logic signed [AWIDTH-1:0]        i_ar,
    input  logic signed [AWIDTH-1:0]        i_ai,
    input  logic signed [BWIDTH-1:0]        i_br,
    input  logic signed [BWIDTH:0]          i_bi,
    output logic signed [AWIDTH+BWIDTH:0]   o_pr,
    output logic signed [AWIDTH+BWIDTH:0]   o_pi
);

    localparam int DW  = AWIDTH + 1;
    localparam int BSW = BWIDTH + 2;
    localparam int PW  = AWIDTH + BWIDTH + 1;

    logic signed [AWIDTH-1:0] r1_ar, r1_ai, r2_ar, r2_ai;
    logic signed [BWIDTH-1:0] r1_br;
    logic signed [BWIDTH:0]   r1_bi, r2_bi;
    logic signed [DW-1:0]     r2_dab;
    logic signed [BSW-1:0]    r2_bsub, r2_badd;
    logic signed [PW-1:0]     r3_common, r3_mr, r3_mi;
    logic signed [PW-1:0]     r4_common, r4_mr, r4_mi;
    logic signed [PW-1:0]     r5_pr, r5_pi;

    // Products are kept modulo 2^PW: the final sums always fit PW bits,
    // so the wrapped partial products still add up to the exact result.
    always_ff @(posedge clk) begin
        r1_ar     <= i_ar;
        r1_ai     <= i_ai;
        r1_br     <= i_br;
        r1_bi     <= i_bi;

        r2_ar     <= r1_ar;
        r2_ai     <= r1_ai;
        r2_bi     <= r1_bi;
        r2_dab    <= DW'(r1_ar) - DW'(r1_ai);
        r2_bsub   <= BSW'(r1_br) - BSW'(r1_bi);
        r2_badd   <= BSW'(r1_br) + BSW'(r1_bi);

        r3_common <= PW'(r2_bi) * PW'(r2_dab);
        r3_mr     <= PW'(r2_ar) * PW'(r2_bsub);
        r3_mi     <= PW'(r2_ai) * PW'(r2_badd);

        r4_common <= r3_common;
        r4_mr     <= r3_mr;
        r4_mi     <= r3_mi;

        r5_pr     <= r4_mr + r4_common;
        r5_pi     <= r4_mi + r4_common;
    end

    assign o_pr = r5_pr;
    assign o_pi = r5_pi;

endmodule

// File: rtl/complex_mac.sv
// Complex multiply-accumulate: optional conjugate of b, per-sample or framed
// accumulation, fixed six-cycle latency.
module complex_mac
    import complex_mac_pkg::*;
#(
    parameter  int AWIDTH = DEF_AWIDTH,
    parameter  int BWIDTH = DEF_BWIDTH,
    parameter  int GUARD  = DEF_GUARD,
    localparam int OWIDTH = owidth(AWIDTH, BWIDTH, GUARD)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_last,
    input  logic                     conj,
    input  logic                     acc_en,
    input  logic signed [AWIDTH-1:0] ar,
    input  logic signed [AWIDTH-1:0] ai,
    input  logic signed [BWIDTH-1:0] br,
    input  logic signed [BWIDTH-1:0] bi,
    output logic                     out_valid,
    output logic signed [OWIDTH-1:0] pr,
    output logic signed [OWIDTH-1:0] pi
);

    localparam int PW = AWIDTH + BWIDTH + 1;

    logic signed [BWIDTH:0]   w_bi_eff;
    logic signed [PW-1:0]     w_core_pr, w_core_pi;
    logic signed [OWIDTH-1:0] w_prod_r, w_prod_i;
    tag_t                     w_tag;

    tag_t                     r_tag [CORE_LATENCY];
    logic signed [OWIDTH-1:0] r_acc_r, r_acc_i, r_pr, r_pi;
    logic                     r_out_valid;

    // One extra bit so that negating the most-negative bi stays exact.
    assign w_bi_eff = conj ? -((BWIDTH+1)'(bi)) : (BWIDTH+1)'(bi);

    complex_mult_core #(
        .AWIDTH (AWIDTH),
        .BWIDTH (BWIDTH)
    ) u_core (
        .clk  (clk),
        .i_ar (ar),
        .i_ai (ai),
        .i_br (br),
        .i_bi (w_bi_eff),
        .o_pr (w_core_pr),
        .o_pi (w_core_pi)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CORE_LATENCY; i++) r_tag[i] <= '0;
        end else begin
            r_tag[0] <= {in_valid, acc_en, in_last};
            for (int i = 1; i < CORE_LATENCY; i++) r_tag[i] <= r_tag[i-1];
        end
    end

    assign w_tag    = r_tag[CORE_LATENCY-1];
    assign w_prod_r = OWIDTH'(w_core_pr);
    assign w_prod_i = OWIDTH'(w_core_pi);

    // Individual samples bypass the accumulator; a frame's last sample
    // emits the sum and restarts the accumulator from zero in the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_r     <= '0;
            r_acc_i     <= '0;
            r_pr        <= '0;
            r_pi        <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_tag.valid & (~w_tag.acc_en | w_tag.last);
            if (w_tag.valid) begin
                if (!w_tag.acc_en) begin
                    r_pr <= w_prod_r;
                    r_pi <= w_prod_i;
                end else if (w_tag.last) begin
                    r_pr    <= r_acc_r + w_prod_r;
                    r_pi    <= r_acc_i + w_prod_i;
                    r_acc_r <= '0;
                    r_acc_i <= '0;
                end else begin
                    r_acc_r <= r_acc_r + w_prod_r;
                    r_acc_i <= r_acc_i + w_prod_i;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign pr        = r_pr;
    assign pi        = r_pi;

endmodule

// File: tb/tb_complex_mac.sv
// Randomised scoreboard bench for complex_mac with directed corner cases.
module tb_complex_mac;

    localparam int AW = 8;
    localparam int BW = 8;
    localparam int G  = 8;
    localparam int OW = AW + BW + 1 + G;
    localparam int LAT = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, in_last = 1'b0, conj = 1'b0, acc_en = 1'b0;
    logic signed [AW-1:0] ar = '0, ai = '0;
    logic signed [BW-1:0] br = '0, bi = '0;
    logic                 out_valid;
    logic signed [OW-1:0] pr, pi;

    complex_mac #(.AWIDTH(AW), .BWIDTH(BW), .GUARD(G)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .conj      (conj),
        .acc_en    (acc_en),
        .ar        (ar),
        .ai        (ai),
        .br        (br),
        .bi        (bi),
        .out_valid (out_valid),
        .pr        (pr),
        .pi        (pi)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int     due;
        longint er;
        longint ei;
        string  name;
    } exp_t;

    exp_t   q[$];
    int     n_vec = 0, n_cmp = 0, n_bad = 0;
    longint acc_r = 0, acc_i = 0;
    longint hold_r = 0, hold_i = 0;

    function automatic longint wrap(input longint v);
        logic signed [OW-1:0] t;
        t = v[OW-1:0];
        return longint'(t);
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d, required %0d", name, cyc, act, req);
        end
    endtask

    // Monitor: compares every presented result against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("unexpected out_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    check({e.name, " timing"}, cyc, e.due);
                    check({e.name, " pr"}, longint'(pr), e.er);
                    check({e.name, " pi"}, longint'(pi), e.ei);
                    hold_r = e.er;
                    hold_i = e.ei;
                end
            end else begin
                check("hold pr", longint'(pr), hold_r);
                check("hold pi", longint'(pi), hold_i);
                if (q.size() > 0 && q[0].due <= cyc) begin
                    e = q.pop_front();
                    check({e.name, " missing out_valid"}, 0, 1);
                end
            end
        end
    end

    // Reference: a*b or a*conj(b) by textbook complex arithmetic.
    task automatic drive(input bit v, input bit r, input int a_r, input int a_i,
                         input int b_r, input int b_i, input bit cj, input bit ae,
                         input bit lst, input bit use_exp, input longint epr,
                         input longint epi, input string name);
        longint p_r, p_i, b_i_eff;
        exp_t   e;
        @(negedge clk);
        rst      = r;
        in_valid = v;
        ar       = AW'(a_r);
        ai       = AW'(a_i);
        br       = BW'(b_r);
        bi       = BW'(b_i);
        conj     = cj;
        acc_en   = ae;
        in_last  = lst;
        if (r) begin
            q.delete();
            acc_r  = 0;
            acc_i  = 0;
            hold_r = 0;
            hold_i = 0;
        end else if (v) begin
            n_vec++;
            b_i_eff = cj ? -longint'(b_i) : longint'(b_i);
            p_r = longint'(a_r) * b_r - longint'(a_i) * b_i_eff;
            p_i = longint'(a_r) * b_i_eff + longint'(a_i) * b_r;
            e.due  = cyc + LAT;
            e.name = name;
            if (!ae) begin
                e.er = wrap(p_r);
                e.ei = wrap(p_i);
            end else if (lst) begin
                e.er = wrap(acc_r + p_r);
                e.ei = wrap(acc_i + p_i);
                acc_r = 0;
                acc_i = 0;
            end else begin
                acc_r = acc_r + p_r;
                acc_i = acc_i + p_i;
            end
            if (!ae || lst) begin
                if (use_exp) begin
                    e.er = epr;
                    e.ei = epi;
                end
                q.push_back(e);
            end
        end
    endtask

    task automatic bubbles(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "bubble");
    endtask

    initial begin
        int a_r, a_i, b_r, b_i;
        repeat (3) drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
        check("reset out_valid", longint'(out_valid), 0);
        check("reset pr", longint'(pr), 0);

        drive(1, 0, 3, 4, 5, -2, 0, 0, 0, 1, 23, 14, "plain product");
        drive(1, 0, 3, 4, 5, -2, 1, 0, 0, 1, 7, 26, "conj product");
        drive(1, 0, -128, -128, -128, -128, 1, 0, 0, 1, 32768, 0, "conj most-negative");
        bubbles(8);

        for (int k = 0; k < 4; k++)
            drive(1, 0, 1, 1, 2, 0, 0, 1, k == 3, k == 3, 8, 8, "frame of four");
        for (int k = 0; k < 4; k++)
            drive(1, 0, 1, 1, 2, 0, 0, 1, k == 3, k == 3, 8, 8, "back-to-back frame");
        bubbles(8);

        drive(1, 0, 1, 1, 2, 0, 0, 1, 0, 0, 0, 0, "interleaved frame");
        bubbles(1);
        drive(1, 0, 1, 1, 2, 0, 0, 1, 0, 0, 0, 0, "interleaved frame");
        drive(1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 1, 0, "interleaved single");
        bubbles(2);
        drive(1, 0, 1, 1, 2, 0, 0, 1, 0, 0, 0, 0, "interleaved frame");
        bubbles(1);
        drive(1, 0, 1, 1, 2, 0, 0, 1, 1, 1, 8, 8, "interleaved frame");
        bubbles(8);

        drive(1, 0, 1, 1, 2, 0, 0, 1, 0, 0, 0, 0, "pre-reset frame");
        drive(1, 0, 1, 1, 2, 0, 0, 1, 0, 0, 0, 0, "pre-reset frame");
        drive(1, 1, 5, 5, 5, 5, 0, 0, 0, 0, 0, 0, "sample during reset");
        drive(1, 0, 1, 1, 2, 0, 0, 1, 0, 0, 0, 0, "post-reset frame");
        drive(1, 0, 1, 1, 2, 0, 0, 1, 1, 1, 4, 4, "post-reset frame");
        bubbles(8);

        for (int n = 0; n < 10000; n++) begin
            a_r = int'($urandom_range(0, 255)) - 128;
            a_i = int'($urandom_range(0, 255)) - 128;
            b_r = int'($urandom_range(0, 255)) - 128;
            b_i = int'($urandom_range(0, 255)) - 128;
            drive(($urandom % 4) != 0, ($urandom % 1500) == 0, a_r, a_i, b_r, b_i,
                  1'($urandom % 2), 1'($urandom % 3 != 0), ($urandom % 12) == 0,
                  0, 0, 0, "random");
        end
        bubbles(10);
        check("queue drained", longint'(q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
